// File: rtl/cla4_mod3_checked_adder.sv
// -----------------------------------------------------------------------------
// cla4_mod3_checked_adder
//
// 4-bit carry-lookahead adder with a mod-3 residue check. Sout = A + B + Cin
// is computed by a flattened CLA. Its residue is compared against the mod-3
// sum of the residues supplied with the operands, and any mismatch is flagged
// on err. Every interesting internal net passes through a stuck-at override
// controlled by fault_en_bus/fault_val, so fault-coverage experiments can
// corrupt the CLA, the residue generator, the residue adder or the comparator.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands valid this cycle
//   A, B         4-bit operands
//   Cin          carry in
//   A_mod3       A mod 3 from the source (code 3 is read as 0)
//   B_mod3       B mod 3 from the source (code 3 is read as 0)
//   fault_en_bus one enable bit per fault ID
//   fault_val    stuck-at value driven onto every enabled net
//   out_valid    Sout/err valid (one cycle after in_valid)
//   Sout         {Cout, S[3:0]}
//   err          residue mismatch detected
//
// Fault ID map (offsets from each base):
//   CLA   : +0..+3 P0..P3, +4..+7 G0..G3, +8..+11 C1..C4, +12..+15 S0..S3
//   RES   : +0..+3 S taps, +4 Cout tap, +5 Q[0], +6 Rsum[0], +7 Rsum[1]
//   MOD3  : +0 A_mod3[0] tap, +1 A_mod3[1] tap, +2 Rab[0], +3 Rab[1]
//   CMP   : +0 err, +1 d0
// -----------------------------------------------------------------------------
module cla4_mod3_checked_adder #(
  parameter int NG            = 128,
  parameter int GID_CLA_BASE  = 0,
  parameter int GID_MOD3_BASE = 20,
  parameter int GID_CMP_BASE  = 30,
  parameter int GID_RES_BASE  = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [3:0]    A,
  input  logic [3:0]    B,
  input  logic          Cin,
  input  logic [1:0]    A_mod3,
  input  logic [1:0]    B_mod3,
  input  logic [NG-1:0] fault_en_bus,
  input  logic          fault_val,
  output logic          out_valid,
  output logic [4:0]    Sout,
  output logic          err
);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Single-net stuck-at override.
  function automatic logic ovr1(input logic net, input logic en, input logic fv);
    return en ? fv : net;
  endfunction

  // Bitwise stuck-at override of a 4-bit group of nets.
  function automatic logic [3:0] ovr4(input logic [3:0] net, input logic [3:0] en,
                                      input logic fv);
    return (net & ~en) | (en & {4{fv}});
  endfunction

  // Residue of a small unsigned value.
  function automatic logic [1:0] mod3(input logic [3:0] v);
    return 2'(v % 4'd3);
  endfunction

  // Canonical residue: the unused code 3 is read as 0.
  function automatic logic [1:0] canon3(input logic [1:0] r);
    return (r == 2'd3) ? 2'd0 : r;
  endfunction

  // ---------------------------------------------------------------------------
  // Fault-enable groups
  // ---------------------------------------------------------------------------
  logic [15:0] en_cla;
  logic [7:0]  en_res;
  logic [3:0]  en_mod3;
  logic [1:0]  en_cmp;
  logic        unused_fault_bits;

  assign en_cla  = fault_en_bus[GID_CLA_BASE  +: 16];
  assign en_res  = fault_en_bus[GID_RES_BASE  +: 8];
  assign en_mod3 = fault_en_bus[GID_MOD3_BASE +: 4];
  assign en_cmp  = fault_en_bus[GID_CMP_BASE  +: 2];

  // IDs outside the map are accepted but have no effect.
  assign unused_fault_bits = ^fault_en_bus;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic [3:0] p, g;
  logic [4:1] c_raw;
  logic [4:0] c;
  logic [3:0] s;
  logic       cout;

  logic [3:0] s_tap;
  logic       cout_tap;
  logic [3:0] q_sum;
  logic [1:0] q_raw, q;
  logic [1:0] rsum_raw, rsum;

  logic [1:0] a_tap, a_res, b_res;
  logic [1:0] rab_raw, rab;

  logic       d0, d1;
  logic       err_c;
  logic [4:0] sout_c;

  always_comb begin
    // Propagate/generate, each bit individually overridable.
    p = ovr4(A ^ B, en_cla[3:0], fault_val);
    g = ovr4(A & B, en_cla[7:4], fault_val);

    // Flattened lookahead: every carry is built from P/G/Cin directly, so an
    // injected carry fault only reaches its own sum bit (and Sout for C4).
    c_raw[1] = g[0] | (p[0] & Cin);
    c_raw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    c_raw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & Cin);
    c_raw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);
    c        = {ovr4(c_raw, en_cla[11:8], fault_val), Cin};

    s    = ovr4(p ^ c[3:0], en_cla[15:12], fault_val);
    cout = c[4];
    sout_c = {cout, s};

    // Sum residue with bit weights 1,2,1,2 for S and 1 for Cout (2^4 = 1 mod 3).
    s_tap    = ovr4(s, en_res[3:0], fault_val);
    cout_tap = ovr1(cout, en_res[4], fault_val);
    q_sum    = {3'b000, s_tap[0]} + {2'b00, s_tap[1], 1'b0}
             + {3'b000, s_tap[2]} + {2'b00, s_tap[3], 1'b0};
    q_raw    = mod3(q_sum);
    // A stuck Q[0] can produce code 3; the following mod3 folds it back.
    q        = {q_raw[1], ovr1(q_raw[0], en_res[5], fault_val)};
    rsum_raw = mod3({2'b00, q} + {3'b000, cout_tap});
    rsum     = {ovr1(rsum_raw[1], en_res[7], fault_val),
                ovr1(rsum_raw[0], en_res[6], fault_val)};

    // Expected residue from the operand residues. Taps are overridden before
    // canonicalisation so a stuck tap can also create the code-3 case.
    a_tap   = {ovr1(A_mod3[1], en_mod3[1], fault_val),
               ovr1(A_mod3[0], en_mod3[0], fault_val)};
    a_res   = canon3(a_tap);
    b_res   = canon3(B_mod3);
    rab_raw = mod3({2'b00, a_res} + {2'b00, b_res} + {3'b000, Cin});
    rab     = {ovr1(rab_raw[1], en_mod3[3], fault_val),
               ovr1(rab_raw[0], en_mod3[2], fault_val)};

    // Comparator.
    d0    = ovr1(rsum[0] ^ rab[0], en_cmp[1], fault_val);
    d1    = rsum[1] ^ rab[1];
    err_c = ovr1(d0 | d1, en_cmp[0], fault_val);
  end

  // ---------------------------------------------------------------------------
  // Stage p0: output registers
  // ---------------------------------------------------------------------------
  logic       vld_p0;
  logic [4:0] sout_p0;
  logic       err_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      sout_p0 <= 5'd0;
      err_p0  <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        sout_p0 <= sout_c;
        err_p0  <= err_c;
      end
    end
  end

  assign out_valid = vld_p0;
  assign Sout      = sout_p0;
  assign err       = err_p0;

endmodule

// File: tb/tb_cla4_mod3_checked_adder.sv
// -----------------------------------------------------------------------------
// tb_cla4_mod3_checked_adder
//
// Directed bench for cla4_mod3_checked_adder: reset, exhaustive fault-free
// sweep, hold behaviour, residue false positives and targeted fault IDs.
// -----------------------------------------------------------------------------
module tb_cla4_mod3_checked_adder;

  localparam int NG = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [3:0]    A, B;
  logic          Cin;
  logic [1:0]    A_mod3, B_mod3;
  logic [NG-1:0] fault_en_bus;
  logic          fault_val;
  logic          out_valid;
  logic [4:0]    Sout;
  logic          err;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  cla4_mod3_checked_adder #(
    .NG(NG), .GID_CLA_BASE(0), .GID_MOD3_BASE(20),
    .GID_CMP_BASE(30), .GID_RES_BASE(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(A), .B(B), .Cin(Cin), .A_mod3(A_mod3), .B_mod3(B_mod3),
    .fault_en_bus(fault_en_bus), .fault_val(fault_val),
    .out_valid(out_valid), .Sout(Sout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one vector on the falling edge, then sample 1 ns after the capture edge.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      input logic [1:0] am, input logic [1:0] bm, input logic v);
    @(negedge clk);
    A = a; B = b; Cin = cin; A_mod3 = am; B_mod3 = bm; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
    A_mod3 = '0; B_mod3 = '0; fault_en_bus = '0; fault_val = 1'b0;

    // Reset state
    @(posedge clk); #1;
    chk("reset_out_valid", {4'd0, out_valid}, 5'd0);
    chk("reset_sout", Sout, 5'd0);
    chk("reset_err", {4'd0, err}, 5'd0);
    @(negedge clk); rst_n = 1'b1;

    // Fault-free exhaustive sweep with correct residues
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          step(4'(ai), 4'(bi), 1'(ci), 2'(ai % 3), 2'(bi % 3), 1'b1);
          chk("sweep_sout", Sout, 5'(ai + bi + ci));
          chk("sweep_err", {4'd0, err}, 5'd0);
          chk("sweep_valid", {4'd0, out_valid}, 5'd1);
        end
      end
    end

    // Spot values
    step(4'd15, 4'd15, 1'b0, 2'd0, 2'd0, 1'b1);
    chk("spot_15_15_sout", Sout, 5'd30);
    chk("spot_15_15_err", {4'd0, err}, 5'd0);
    step(4'd7, 4'd9, 1'b1, 2'd1, 2'd0, 1'b1);
    chk("spot_7_9_1_sout", Sout, 5'd17);
    chk("spot_7_9_1_err", {4'd0, err}, 5'd0);

    // in_valid low: out_valid drops, Sout/err hold
    step(4'd1, 4'd2, 1'b0, 2'd1, 2'd2, 1'b0);
    chk("hold_valid", {4'd0, out_valid}, 5'd0);
    chk("hold_sout", Sout, 5'd17);
    chk("hold_err", {4'd0, err}, 5'd0);

    // Residue code 3 read as 0 (A=3 -> code 3 is a valid spelling of 0)
    step(4'd3, 4'd5, 1'b0, 2'd3, 2'd2, 1'b1);
    chk("code3_sout", Sout, 5'd8);
    chk("code3_err", {4'd0, err}, 5'd0);

    // Wrong supplied residue, correct sum -> false positive
    step(4'd4, 4'd4, 1'b0, 2'd0, 2'd1, 1'b1);
    chk("badres_sout", Sout, 5'd8);
    chk("badres_err", {4'd0, err}, 5'd1);

    // Fault ID 12 (S0) stuck at 1: 2+2 -> 5, Rsum=2, Rab=1
    fault_en_bus = '0; fault_en_bus[12] = 1'b1; fault_val = 1'b1;
    step(4'd2, 4'd2, 1'b0, 2'd2, 2'd2, 1'b1);
    chk("f12_sout", Sout, 5'd5);
    chk("f12_err", {4'd0, err}, 5'd1);

    // Fault ID 30 (err) stuck at 1 with a clean datapath
    fault_en_bus = '0; fault_en_bus[30] = 1'b1; fault_val = 1'b1;
    step(4'd3, 4'd4, 1'b0, 2'd0, 2'd1, 1'b1);
    chk("f30_sout", Sout, 5'd7);
    chk("f30_err", {4'd0, err}, 5'd1);

    // Fault ID 23 (Rab[1]) stuck at 0: Rab 2 -> 0 against Rsum 2
    fault_en_bus = '0; fault_en_bus[23] = 1'b1; fault_val = 1'b0;
    step(4'd1, 4'd1, 1'b0, 2'd1, 2'd1, 1'b1);
    chk("f23_sout", Sout, 5'd2);
    chk("f23_err", {4'd0, err}, 5'd1);

    // Fault IDs 30 and 40 stuck at 0: err masked even with wrong residues
    fault_en_bus = '0; fault_en_bus[30] = 1'b1; fault_en_bus[40] = 1'b1;
    fault_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(4'(2 * i), 4'(15 - i), 1'(i % 2), 2'(((2 * i) % 3 + 1) % 3),
           2'((15 - i) % 3), 1'b1);
      chk("f30_40_sout", Sout, 5'(2 * i + 15 - i + (i % 2)));
      chk("f30_40_err", {4'd0, err}, 5'd0);
    end

    // Faults removed: same wrong residue is flagged again
    fault_en_bus = '0;
    step(4'd5, 4'd6, 1'b1, 2'd0, 2'd0, 1'b1);
    chk("nofault_sout", Sout, 5'd12);
    chk("nofault_err", {4'd0, err}, 5'd1);

    // Asynchronous reset mid-operation, away from any clock edge
    @(negedge clk);
    A = 4'd9; B = 4'd9; Cin = 1'b0; A_mod3 = 2'd0; B_mod3 = 2'd0; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {4'd0, out_valid}, 5'd0);
    chk("async_rst_sout", Sout, 5'd0);
    chk("async_rst_err", {4'd0, err}, 5'd0);
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;

    // First result after reset
    step(4'd9, 4'd9, 1'b0, 2'd0, 2'd0, 1'b1);
    chk("post_rst_sout", Sout, 5'd18);
    chk("post_rst_valid", {4'd0, out_valid}, 5'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
